// File: rtl/hwpe_l2_pkg.sv
// Shared constants and request bundle type for the HWPE-to-L2 funnel.
package hwpe_l2_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] add;
      logic              wen;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } tcdm_req_t;

endpackage

// File: rtl/hwpe_l2_id_fifo.sv
// Small synchronous FIFO used to remember which port owns each in-flight L2 request.
module hwpe_l2_id_fifo #(
   parameter  int unsigned WIDTH = 2,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic                        do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; entries are only read after being written.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/hwpe_l2_mux.sv
// Round-robin funnel of N TCDM-style HWPE master ports onto one L2 port, with in-order response routing.
module hwpe_l2_mux
   import hwpe_l2_pkg::*;
#(
   parameter int unsigned N_PORTS         = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [N_PORTS-1:0]               s_req_i,
   output logic [N_PORTS-1:0]               s_gnt_o,
   input  logic [N_PORTS-1:0][ADDR_W-1:0]   s_add_i,
   input  logic [N_PORTS-1:0]               s_wen_i,
   input  logic [N_PORTS-1:0][BE_W-1:0]     s_be_i,
   input  logic [N_PORTS-1:0][DATA_W-1:0]   s_wdata_i,
   output logic [N_PORTS-1:0][DATA_W-1:0]   s_r_rdata_o,
   output logic [N_PORTS-1:0]               s_r_valid_o,
   output logic                             m_req_o,
   output logic [ADDR_W-1:0]                m_add_o,
   output logic                             m_wen_o,
   output logic [BE_W-1:0]                  m_be_o,
   output logic [DATA_W-1:0]                m_wdata_o,
   input  logic                             m_gnt_i,
   input  logic [DATA_W-1:0]                m_r_rdata_i,
   input  logic                             m_r_valid_i,
   output logic                             busy_o,
   output logic                             err_o
);

   localparam int unsigned IDX_W = $clog2(N_PORTS);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   tcdm_req_t                        port_req [N_PORTS];
   tcdm_req_t                        win_req;
   logic                             any_req, handshake, rsp_pop;
   logic [IDX_W-1:0]                 win_idx;
   logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
   logic                             err_q, err_d;
   logic [N_PORTS-1:0]               r_valid_q, r_valid_d;
   logic [N_PORTS-1:0][DATA_W-1:0]   r_rdata_q, r_rdata_d;
   logic [IDX_W-1:0]                 fifo_head;
   logic                             fifo_full, fifo_empty;
   logic [CNT_W-1:0]                 fifo_count;

   always_comb begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         port_req[i] = '{add: s_add_i[i], wen: s_wen_i[i], be: s_be_i[i], wdata: s_wdata_i[i]};
      end
   end

   // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      found   = 1'b0;
      cand    = '0;
      win_idx = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         cand = IDX_W'((32'(rr_ptr_q) + i) % N_PORTS);
         if (!found && s_req_i[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign any_req   = |s_req_i;
   assign win_req   = any_req ? port_req[win_idx] : '0;
   assign m_add_o   = win_req.add;
   assign m_wen_o   = win_req.wen;
   assign m_be_o    = win_req.be;
   assign m_wdata_o = win_req.wdata;

   // Fullness uses the registered count only, keeping m_r_valid_i off the grant path.
   assign m_req_o   = any_req & ~fifo_full;
   assign handshake = m_req_o & m_gnt_i;
   assign rsp_pop   = m_r_valid_i & ~fifo_empty;

   always_comb begin
      s_gnt_o = '0;
      if (handshake) s_gnt_o[win_idx] = 1'b1;
   end

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      err_d     = err_q | (m_r_valid_i & fifo_empty);
      r_valid_d = '0;
      r_rdata_d = r_rdata_q;
      if (handshake) begin
         rr_ptr_d = (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
      end
      if (rsp_pop) begin
         r_valid_d[fifo_head] = 1'b1;
         r_rdata_d[fifo_head] = m_r_rdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q  <= '0;
         err_q     <= 1'b0;
         r_valid_q <= '0;
         r_rdata_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         err_q     <= err_d;
         r_valid_q <= r_valid_d;
         r_rdata_q <= r_rdata_d;
      end
   end

   hwpe_l2_id_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (MAX_OUTSTANDING)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (handshake),
      .pop_i   (rsp_pop),
      .data_i  (win_idx),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign s_r_valid_o = r_valid_q;
   assign s_r_rdata_o = r_rdata_q;
   assign err_o       = err_q;
   // Outstanding IDs are ignored while reset is held, since they are about to be discarded.
   assign busy_o      = any_req | (~rst_i & (fifo_count != '0));

endmodule

// File: tb/tb_hwpe_l2_mux.sv
// Directed self-checking bench for hwpe_l2_mux with hand-computed expectations.
module tb_hwpe_l2_mux;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [3:0]        s_req_i;
   logic [3:0]        s_gnt_o;
   logic [3:0][31:0]  s_add_i;
   logic [3:0]        s_wen_i;
   logic [3:0][3:0]   s_be_i;
   logic [3:0][31:0]  s_wdata_i;
   logic [3:0][31:0]  s_r_rdata_o;
   logic [3:0]        s_r_valid_o;
   logic              m_req_o;
   logic [31:0]       m_add_o;
   logic              m_wen_o;
   logic [3:0]        m_be_o;
   logic [31:0]       m_wdata_o;
   logic              m_gnt_i;
   logic [31:0]       m_r_rdata_i;
   logic              m_r_valid_i;
   logic              busy_o;
   logic              err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   hwpe_l2_mux #(.N_PORTS(4), .MAX_OUTSTANDING(4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .s_req_i     (s_req_i),
      .s_gnt_o     (s_gnt_o),
      .s_add_i     (s_add_i),
      .s_wen_i     (s_wen_i),
      .s_be_i      (s_be_i),
      .s_wdata_i   (s_wdata_i),
      .s_r_rdata_o (s_r_rdata_o),
      .s_r_valid_o (s_r_valid_o),
      .m_req_o     (m_req_o),
      .m_add_o     (m_add_o),
      .m_wen_o     (m_wen_o),
      .m_be_o      (m_be_o),
      .m_wdata_o   (m_wdata_o),
      .m_gnt_i     (m_gnt_i),
      .m_r_rdata_i (m_r_rdata_i),
      .m_r_valid_i (m_r_valid_i),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled before the next one.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      s_req_i     = '0;
      s_add_i     = '0;
      s_wen_i     = '1;
      s_be_i      = '0;
      s_wdata_i   = '0;
      m_gnt_i     = 1'b0;
      m_r_rdata_i = '0;
      m_r_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      idle_inputs();
      do_reset();

      // Reset state
      settle();
      check("rst_rvalid", 32'(s_r_valid_o), 32'h0);
      check("rst_rdata2", s_r_rdata_o[2], 32'h0);
      check("rst_err", 32'(err_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      check("rst_mreq", 32'(m_req_o), 32'h0);
      check("rst_madd", m_add_o, 32'h0);

      // Single read from port 2
      s_req_i[2] = 1'b1;
      s_add_i[2] = 32'h1C00_0010;
      s_wen_i[2] = 1'b1;
      s_be_i[2]  = 4'hF;
      m_gnt_i    = 1'b1;
      settle();
      check("single_gnt", 32'(s_gnt_o), 32'h4);
      check("single_madd", m_add_o, 32'h1C00_0010);
      check("single_mwen", 32'(m_wen_o), 32'h1);
      tick();
      s_req_i     = '0;
      m_r_valid_i = 1'b1;
      m_r_rdata_i = 32'hDEAD_BEEF;
      settle();
      check("single_busy_fifo", 32'(busy_o), 32'h1);
      check("single_rvalid_early", 32'(s_r_valid_o), 32'h0);
      tick();
      m_r_valid_i = 1'b0;
      settle();
      check("single_rvalid", 32'(s_r_valid_o), 32'h4);
      check("single_rdata", s_r_rdata_o[2], 32'hDEAD_BEEF);
      check("single_busy_idle", 32'(busy_o), 32'h0);

      // All ports continuously requesting, 1-cycle response latency
      do_reset();
      for (int p = 0; p < 4; p++) begin
         s_req_i[p]   = 1'b1;
         s_add_i[p]   = 32'h1000_0000 + 32'(p) * 32'h100;
         s_wen_i[p]   = 1'b1;
         s_be_i[p]    = 4'hF;
      end
      m_gnt_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         m_r_valid_i = (k > 0);
         m_r_rdata_i = 32'hA000_0000 + 32'(k - 1);
         settle();
         check($sformatf("rr_gnt_%0d", k), 32'(s_gnt_o), 32'(1 << (k % 4)));
         check($sformatf("rr_madd_%0d", k), m_add_o, 32'h1000_0000 + 32'(k % 4) * 32'h100);
         tick();
         if (k > 0) begin
            check($sformatf("rr_rvalid_%0d", k), 32'(s_r_valid_o), 32'(1 << ((k - 1) % 4)));
            check($sformatf("rr_rdata_%0d", k), s_r_rdata_o[(k - 1) % 4], 32'hA000_0000 + 32'(k - 1));
         end
      end
      s_req_i     = '0;
      m_r_valid_i = 1'b1;
      m_r_rdata_i = 32'hA000_0007;
      tick();
      m_r_valid_i = 1'b0;
      settle();
      check("rr_rvalid_last", 32'(s_r_valid_o), 32'h8);
      check("rr_rdata_last", s_r_rdata_o[3], 32'hA000_0007);
      check("rr_rdata_keep0", s_r_rdata_o[0], 32'hA000_0004);

      // Full FIFO blocks grants; a pop does not release a grant in the same cycle
      do_reset();
      s_req_i = 4'hF;
      m_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         check($sformatf("full_gnt_%0d", k), 32'(s_gnt_o), 32'(1 << k));
         tick();
      end
      settle();
      check("full_mreq", 32'(m_req_o), 32'h0);
      check("full_gnt", 32'(s_gnt_o), 32'h0);
      m_r_valid_i = 1'b1;
      m_r_rdata_i = 32'h0000_00F0;
      settle();
      check("full_pop_same_cycle_gnt", 32'(s_gnt_o), 32'h0);
      tick();
      m_r_valid_i = 1'b0;
      settle();
      check("full_next_gnt", 32'(s_gnt_o), 32'h1);
      check("full_pop_rvalid", 32'(s_r_valid_o), 32'h1);
      check("full_pop_rdata", s_r_rdata_o[0], 32'h0000_00F0);
      tick();
      s_req_i = '0;
      for (int k = 0; k < 4; k++) begin
         m_r_valid_i = 1'b1;
         m_r_rdata_i = 32'h0000_00F1 + 32'(k);
         tick();
         check($sformatf("full_drain_rvalid_%0d", k), 32'(s_r_valid_o), 32'(1 << ((k + 1) % 4)));
         check($sformatf("full_drain_rdata_%0d", k), s_r_rdata_o[(k + 1) % 4], 32'h0000_00F1 + 32'(k));
      end
      m_r_valid_i = 1'b0;
      settle();
      check("full_drain_busy", 32'(busy_o), 32'h0);

      // Writes from ports 1 and 3 with stalled grants/responses; rr_ptr is 1 here
      s_req_i      = 4'b1010;
      s_add_i[1]   = 32'h1C00_1000;
      s_wdata_i[1] = 32'h1111_1111;
      s_add_i[3]   = 32'h1C00_3000;
      s_wdata_i[3] = 32'h3333_3333;
      s_wen_i      = 4'b0101;
      s_be_i[1]    = 4'b0011;
      s_be_i[3]    = 4'b0011;
      m_gnt_i      = 1'b0;
      settle();
      check("wr_stall_gnt", 32'(s_gnt_o), 32'h0);
      check("wr_stall_madd", m_add_o, 32'h1C00_1000);
      check("wr_stall_mwen", 32'(m_wen_o), 32'h0);
      check("wr_stall_mbe", 32'(m_be_o), 32'h3);
      tick();
      settle();
      check("wr_stall2_madd", m_add_o, 32'h1C00_1000);
      check("wr_stall2_mwdata", m_wdata_o, 32'h1111_1111);
      m_gnt_i = 1'b1;
      settle();
      check("wr_gnt_p1", 32'(s_gnt_o), 32'h2);
      tick();
      s_req_i = 4'b1000;
      m_gnt_i = 1'b0;
      settle();
      check("wr_stall_p3_madd", m_add_o, 32'h1C00_3000);
      tick();
      m_gnt_i     = 1'b1;
      m_r_valid_i = 1'b1;
      m_r_rdata_i = 32'h0000_0011;
      settle();
      check("wr_gnt_p3", 32'(s_gnt_o), 32'h8);
      tick();
      check("wr_rsp_p1_valid", 32'(s_r_valid_o), 32'h2);
      check("wr_rsp_p1_data", s_r_rdata_o[1], 32'h0000_0011);
      s_req_i      = 4'b0010;
      s_add_i[1]   = 32'h1C00_1004;
      s_wdata_i[1] = 32'h1B1B_1B1B;
      m_r_valid_i  = 1'b0;
      settle();
      check("wr_gnt_p1b", 32'(s_gnt_o), 32'h2);
      check("wr_p1b_madd", m_add_o, 32'h1C00_1004);
      tick();
      check("wr_no_rsp", 32'(s_r_valid_o), 32'h0);
      s_req_i     = '0;
      m_gnt_i     = 1'b0;
      m_r_valid_i = 1'b1;
      m_r_rdata_i = 32'h0000_0033;
      tick();
      check("wr_rsp_p3_valid", 32'(s_r_valid_o), 32'h8);
      check("wr_rsp_p3_data", s_r_rdata_o[3], 32'h0000_0033);
      check("wr_keep_p1_data", s_r_rdata_o[1], 32'h0000_0011);
      m_r_rdata_i = 32'h0000_001B;
      tick();
      check("wr_rsp_p1b_valid", 32'(s_r_valid_o), 32'h2);
      check("wr_rsp_p1b_data", s_r_rdata_o[1], 32'h0000_001B);
      m_r_valid_i = 1'b0;
      settle();
      check("wr_idle_busy", 32'(busy_o), 32'h0);
      check("wr_no_err", 32'(err_o), 32'h0);

      // Response with empty FIFO sets sticky error
      m_r_valid_i = 1'b1;
      m_r_rdata_i = 32'hBAD0_BAD0;
      tick();
      m_r_valid_i = 1'b0;
      check("err_set", 32'(err_o), 32'h1);
      check("err_no_rvalid", 32'(s_r_valid_o), 32'h0);
      tick();
      tick();
      check("err_sticky", 32'(err_o), 32'h1);

      // Reset with 3 outstanding requests
      do_reset();
      settle();
      check("rst2_err_clear", 32'(err_o), 32'h0);
      s_req_i = 4'b0111;
      m_gnt_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("pre_rst_gnt_%0d", k), 32'(s_gnt_o), 32'(1 << k));
         tick();
         s_req_i[k] = 1'b0;
      end
      settle();
      check("pre_rst_busy", 32'(busy_o), 32'h1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      settle();
      check("post_rst_busy", 32'(busy_o), 32'h0);
      check("post_rst_rvalid", 32'(s_r_valid_o), 32'h0);
      s_req_i = 4'b1010;
      settle();
      check("post_rst_rr_gnt", 32'(s_gnt_o), 32'h2);
      s_req_i = '0;
      m_gnt_i = 1'b0;
      m_r_valid_i = 1'b1;
      tick();
      m_r_valid_i = 1'b0;
      check("late_rsp_err", 32'(err_o), 32'h1);
      check("late_rsp_no_rvalid", 32'(s_r_valid_o), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
